// File: rtl/piggy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : piggy_pkg
// Desc     : Shared constants and FSM state encoding for the report sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package piggy_pkg;

    localparam int         FRAME_LEN  = 25;
    localparam logic [4:0] c_last_idx = 5'(FRAME_LEN - 1);

    localparam logic [7:0] c_tag_t = 8'h54;
    localparam logic [7:0] c_tag_f = 8'h46;
    localparam logic [7:0] c_tag_w = 8'h57;
    localparam logic [7:0] c_tag_o = 8'h4F;
    localparam logic [7:0] c_eq    = 8'h3D;
    localparam logic [7:0] c_comma = 8'h2C;
    localparam logic [7:0] c_cr    = 8'h0D;
    localparam logic [7:0] c_lf    = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/piggy_frame_mux.sv
`default_nettype none
// ============================================================================
// Module   : piggy_frame_mux
// Desc     : Selects byte idx of "T=ddd,F=ddd,W=ddd,O=ddd\r\n" from the snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module piggy_frame_mux
    import piggy_pkg::*;
(
    input  logic [4:0]  idx,
    input  logic [95:0] snapshot,
    output logic [7:0]  frame_byte
);

    // snapshot layout: {ten, five, two, one}, each hundreds-first
    always_comb begin
        frame_byte = 8'h00;
        case (idx)
            5'd0:                    frame_byte = c_tag_t;
            5'd1, 5'd7, 5'd13, 5'd19: frame_byte = c_eq;
            5'd2:                    frame_byte = snapshot[95:88];
            5'd3:                    frame_byte = snapshot[87:80];
            5'd4:                    frame_byte = snapshot[79:72];
            5'd5, 5'd11, 5'd17:      frame_byte = c_comma;
            5'd6:                    frame_byte = c_tag_f;
            5'd8:                    frame_byte = snapshot[71:64];
            5'd9:                    frame_byte = snapshot[63:56];
            5'd10:                   frame_byte = snapshot[55:48];
            5'd12:                   frame_byte = c_tag_w;
            5'd14:                   frame_byte = snapshot[47:40];
            5'd15:                   frame_byte = snapshot[39:32];
            5'd16:                   frame_byte = snapshot[31:24];
            5'd18:                   frame_byte = c_tag_o;
            5'd20:                   frame_byte = snapshot[23:16];
            5'd21:                   frame_byte = snapshot[15:8];
            5'd22:                   frame_byte = snapshot[7:0];
            5'd23:                   frame_byte = c_cr;
            5'd24:                   frame_byte = c_lf;
            default:                 frame_byte = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/piggy_report_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : piggy_report_sequencer
// Desc     : Triggers, snapshots and streams balance-report frames to uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
module piggy_report_sequencer
    import piggy_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  change_in,
    input  logic        report_req,
    input  logic [23:0] ten_ascii,
    input  logic [23:0] five_ascii,
    input  logic [23:0] two_ascii,
    input  logic [23:0] one_ascii,
    input  logic        tx_active,
    input  logic        tx_done,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

    localparam logic [TIMER_W-1:0] c_timer_last = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_timer_max  = '1;
    localparam logic [GAP_W-1:0]   c_gap_last   = GAP_W'(GAP_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [4:0]           r_idx;
    logic [TIMER_W-1:0]   r_timer;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic                 r_pending;
    logic [95:0]          r_snapshot;
    logic [7:0]           r_tx_byte;
    logic [7:0]           w_frame_byte;
    logic                 w_trig;

    assign w_trig = (|change_in) | report_req;

    piggy_frame_mux u_frame_mux (
        .idx        (r_idx),
        .snapshot   (r_snapshot),
        .frame_byte (w_frame_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tx_dv       = 1'b0;
        frame_done  = 1'b0;
        timeout_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trig || r_pending) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!tx_active) begin
                    tx_dv       = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // an acknowledge beats a timeout landing on the same cycle
                if (tx_done) begin
                    if (r_idx == c_last_idx) begin
                        frame_done  = 1'b1;
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                    end
                end else if (r_timer == c_timer_last) begin
                    timeout_err = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= 5'd0;
            r_timer    <= '0;
            r_gap_cnt  <= '0;
            r_pending  <= 1'b0;
            r_snapshot <= '0;
            r_tx_byte  <= 8'h00;
        end else begin
            // a trigger arriving in LOAD re-arms pending for a follow-up frame
            r_pending <= w_trig | (r_pending & (r_state != ST_LOAD));
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + GAP_W'(1) : '0;

            case (r_state)
                ST_LOAD: begin
                    r_snapshot <= {ten_ascii, five_ascii, two_ascii, one_ascii};
                    r_idx      <= 5'd0;
                end
                ST_ISSUE: begin
                    if (tx_dv) begin
                        r_tx_byte <= w_frame_byte;
                        r_timer   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (tx_done && (r_idx != c_last_idx)) begin
                        r_idx <= r_idx + 5'd1;
                    end
                    if (r_timer != c_timer_max) begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // the live byte is presented on the strobe cycle, then held until the next one
    assign tx_byte = tx_dv ? w_frame_byte : r_tx_byte;
    assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_piggy_report_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piggy_report_sequencer
// Desc     : Self-checking bench with a frame-level reference model and a UART model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piggy_report_sequencer;

    localparam int TO = 40;
    localparam int GP = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  change_in = 4'd0;
    logic        report_req = 1'b0;
    logic [23:0] ten_ascii = 24'h303132;
    logic [23:0] five_ascii = 24'h303033;
    logic [23:0] two_ascii = 24'h303030;
    logic [23:0] one_ascii = 24'h303037;
    logic        tx_active = 1'b0;
    logic        tx_done = 1'b0;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;

    piggy_report_sequencer #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP)) dut (
        .clk(clk), .reset(reset), .change_in(change_in), .report_req(report_req),
        .ten_ascii(ten_ascii), .five_ascii(five_ascii), .two_ascii(two_ascii),
        .one_ascii(one_ascii), .tx_active(tx_active), .tx_done(tx_done),
        .tx_dv(tx_dv), .tx_byte(tx_byte), .busy(busy), .frame_done(frame_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- UART model ----------------
    int uart_cnt = 0, uart_pos = 0, drop_pos = -1, bp_pos = -1, bp_left = 0;
    int bp_done_cyc = 0, bp_dv_cyc = 0, drop_cyc = 0;
    bit bp_wait_dv = 1'b0, rand_ack = 1'b0, rand_drop = 1'b0;

    always @(negedge clk) begin
        if (tx_dv) begin
            uart_pos = (tx_byte == 8'h54) ? 0 : uart_pos + 1;
            if (bp_wait_dv) begin
                bp_dv_cyc  = cyc;
                bp_wait_dv = 1'b0;
            end
            if (uart_pos == drop_pos || (rand_drop && $urandom_range(0, 39) == 0)) begin
                drop_cyc = cyc;
                drop_pos = -1;
                uart_cnt = 0;
            end else begin
                uart_cnt = rand_ack ? int'($urandom_range(1, 12)) : 10;
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        tx_done = 1'b0;
        if (bp_left > 0) bp_left--;
        if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
                tx_done = 1'b1;
                if (uart_pos == bp_pos) begin
                    bp_left     = 51;
                    bp_pos      = -1;
                    bp_done_cyc = cyc;
                    bp_wait_dv  = 1'b1;
                end
            end
        end
        tx_active = (uart_cnt > 0) || (bp_left > 0);
    end

    // ---------------- reference model ----------------
    // phases: 0 idle, 1 load, 2 issue, 3 wait, 4 gap
    int         m_ph = 0, m_pos = 0, m_wait = 0, m_gap = 0, nph;
    bit         m_pend = 1'b0;
    logic [7:0] m_last = 8'h00;
    logic [7:0] m_frame [25];
    logic [7:0] rx [$];
    bit         e_trig, e_dv, e_fd, e_to, e_busy;
    logic [7:0] e_byte;
    string      fs;

    always @(negedge clk) begin
        e_trig = (|change_in) || report_req;
        e_dv   = (m_ph == 2) && !tx_active;
        e_byte = e_dv ? m_frame[m_pos] : m_last;
        e_fd   = (m_ph == 3) && tx_done && (m_pos == 24);
        e_to   = (m_ph == 3) && !tx_done && (m_wait == TO - 1);
        e_busy = (m_ph != 0);
        if (chk_en) begin
            chk("tx_dv", 32'(tx_dv), 32'(e_dv));
            chk("tx_byte", 32'(tx_byte), 32'(e_byte));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
            chk("timeout_err", 32'(timeout_err), 32'(e_to));
        end
        if (tx_dv) rx.push_back(tx_byte);

        if (reset) begin
            m_ph = 0; m_pos = 0; m_wait = 0; m_gap = 0; m_pend = 1'b0; m_last = 8'h00;
        end else begin
            nph = m_ph;
            case (m_ph)
                0: if (e_trig || m_pend) nph = 1;
                1: begin
                    fs = $sformatf("T=%s,F=%s,W=%s,O=%s\r\n", ten_ascii, five_ascii, two_ascii, one_ascii);
                    for (int i = 0; i < 25; i++) m_frame[i] = fs[i];
                    m_pos = 0;
                    nph = 2;
                end
                2: if (!tx_active) begin
                    m_last = m_frame[m_pos];
                    m_wait = 0;
                    nph = 3;
                end
                3: if (tx_done) begin
                    if (m_pos == 24) begin m_gap = GP; nph = 4; end
                    else begin m_pos++; nph = 2; end
                end else if (m_wait == TO - 1) begin
                    m_gap = GP; nph = 4;
                end else begin
                    m_wait++;
                end
                default: begin
                    m_gap--;
                    if (m_gap == 0) nph = 0;
                end
            endcase
            m_pend = e_trig || (m_pend && m_ph != 1);
            m_ph = nph;
        end
    end

    // ---------------- stimulus helpers ----------------
    // kind: 0 frame_done, 1 timeout_err, 2 busy low
    task automatic wait_sig(input int kind, input int limit, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if ((kind == 0 && frame_done) || (kind == 1 && timeout_err) || (kind == 2 && !busy)) return;
            if (n >= limit) begin
                n_total++;
                $display("FAIL wait_kind%0d: event not seen within %0d cycles", kind, limit);
                return;
            end
        end
    endtask

    task automatic wait_rx(input int want, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (rx.size() >= want) return;
        end
        n_total++;
        $display("FAIL wait_rx: only %0d bytes, wanted %0d", rx.size(), want);
    endtask

    task automatic pulse_req();
        @(posedge clk); #1; report_req = 1'b1;
        @(posedge clk); #1; report_req = 1'b0;
    endtask

    function automatic logic [23:0] rnd3();
        return {8'h30 + 8'($urandom_range(0, 9)), 8'h30 + 8'($urandom_range(0, 9)),
                8'h30 + 8'($urandom_range(0, 9))};
    endfunction

    // ---------------- directed + random sequence ----------------
    string exp1 = "T=012,F=003,W=000,O=007\r\n";
    int    n;

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_tx_dv", 32'(tx_dv), 0);
        chk("rst_tx_byte", 32'(tx_byte), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);

        // single report and latency
        rx.delete();
        pulse_req();
        @(negedge clk);
        chk("lat_load_busy", 32'(busy), 1);
        chk("lat_load_dv", 32'(tx_dv), 0);
        @(negedge clk);
        chk("lat_first_dv", 32'(tx_dv), 1);
        chk("lat_first_byte", 32'(tx_byte), 32'h54);
        wait_sig(0, 600, n);
        chk("frame1_len", rx.size(), 25);
        for (int i = 0; i < 25; i++) chk($sformatf("frame1_byte%0d", i), 32'(rx[i]), 32'(exp1[i]));
        wait_sig(2, 50, n);
        chk("gap_len", n, GP + 1);

        // coalescing and snapshot integrity
        rx.delete();
        pulse_req();
        wait_rx(6, 400);
        for (int i = 0; i < 3; i++) begin
            change_in = 4'b0001 << i;
            @(posedge clk); #1 change_in = 4'd0;
            @(posedge clk); #1;
        end
        wait_rx(9, 400);
        ten_ascii = 24'h303133;
        wait_sig(0, 600, n);
        wait_sig(0, 800, n);
        wait_sig(2, 50, n);
        repeat (30) @(posedge clk);
        #1;
        chk("coalesce_bytes", rx.size(), 50);
        chk("coalesce_idle", 32'(busy), 0);
        chk("snap_old_units", 32'(rx[4]), 32'h32);
        chk("snap_new_tens", 32'(rx[28]), 32'h31);
        chk("snap_new_units", 32'(rx[29]), 32'h33);

        // timeout without pending: no retry
        rx.delete();
        drop_pos = 3;
        pulse_req();
        wait_sig(1, 400, n);
        chk("timeout_delay", cyc - drop_cyc, TO);
        chk("timeout_bytes", rx.size(), 4);
        wait_sig(2, 50, n);
        chk("timeout_gap", n, GP + 1);
        repeat (20) @(posedge clk);
        #1;
        chk("timeout_no_retry_busy", 32'(busy), 0);
        chk("timeout_no_retry_bytes", rx.size(), 4);

        // timeout with pending: frame retried
        rx.delete();
        drop_pos = 3;
        pulse_req();
        wait_rx(4, 400);
        pulse_req();
        wait_sig(1, 400, n);
        wait_sig(0, 800, n);
        chk("retry_bytes", rx.size(), 29);
        chk("retry_first", 32'(rx[4]), 32'h54);
        wait_sig(2, 50, n);

        // backpressure before byte 7
        rx.delete();
        bp_pos = 6;
        pulse_req();
        wait_sig(0, 900, n);
        chk("bp_stall", bp_dv_cyc - bp_done_cyc, 51);
        chk("bp_bytes", rx.size(), 25);
        wait_sig(2, 50, n);

        // reset mid-frame
        rx.delete();
        pulse_req();
        wait_rx(11, 400);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx_dv", 32'(tx_dv), 0);
        chk("mid_rst_tx_byte", 32'(tx_byte), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_frame_done", 32'(frame_done), 0);
        chk("mid_rst_timeout_err", 32'(timeout_err), 0);
        repeat (15) @(posedge clk);
        #1 rx.delete();
        pulse_req();
        @(negedge clk);
        @(negedge clk);
        chk("restart_dv", 32'(tx_dv), 1);
        chk("restart_byte", 32'(tx_byte), 32'h54);
        wait_sig(0, 600, n);
        chk("restart_bytes", rx.size(), 25);
        wait_sig(2, 50, n);

        // randomized traffic
        rand_ack  = 1'b1;
        rand_drop = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            change_in  = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'd0;
            report_req = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) == 0) ten_ascii  = rnd3();
            if ($urandom_range(0, 99) == 0) five_ascii = rnd3();
            if ($urandom_range(0, 99) == 0) two_ascii  = rnd3();
            if ($urandom_range(0, 99) == 0) one_ascii  = rnd3();
            reset = ($urandom_range(0, 999) == 0);
        end
        @(posedge clk); #1;
        change_in = 4'd0; report_req = 1'b0; reset = 1'b0; rand_drop = 1'b0;
        wait_sig(2, 3000, n);
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
